flit_credit_injector: RTL

//  Transmit-side endpoint of a router input port: segments local packets into head/body/tail flits,

---
 rtl/flit_credit_injector_pkg.sv | 21 ++
 rtl/injector_credit_counter.sv | 25 ++
 rtl/flit_credit_injector.sv | 93 +++++++++
 3 files changed

// File: rtl/flit_credit_injector_pkg.sv
// flit_credit_injector_pkg: shared packet-size limits, flit flag type and one-hot VC helper.
package flit_credit_injector_pkg;

    localparam int MIN_PCK_SIZE     = 1;
    localparam int DEF_MAX_PCK_SIZE = 16;

    typedef enum logic {
        IDLE,
        BODY
    } inj_state_t;

    typedef struct packed {
        logic hdr;
        logic tail;
    } flit_flag_t;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/injector_credit_counter.sv
// injector_credit_counter: per-VC credit count, starts full at B, saturates on an over-return.
module injector_credit_counter #(
    parameter int B  = 4,
    parameter int Cw = $clog2(B + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue,
    input  logic          ret,
    output logic [Cw-1:0] cnt,
    output logic          has_credit,
    output logic          ovf
);

    assign has_credit = cnt != '0;
    // A return with nothing outstanding is dropped and flagged instead of wrapping.
    assign ovf = ret && !issue && cnt == Cw'(B);

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            cnt <= Cw'(B);
        else if (!ovf && issue != ret)
            cnt <= issue ? cnt - Cw'(1) : cnt + Cw'(1);

endmodule

// File: rtl/flit_credit_injector.sv
// flit_credit_injector: segments packets into head/body/tail flits and issues them
// toward a router input port only when the target VC holds a credit.
module flit_credit_injector
    import flit_credit_injector_pkg::*;
#(
    parameter int V            = 2,
    parameter int B            = 4,
    parameter int Fpay         = 32,
    parameter int MAX_PCK_SIZE = DEF_MAX_PCK_SIZE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pck_valid,
    output logic                              pck_ready,
    input  logic [V-1:0]                      pck_vc,
    input  logic [$clog2(MAX_PCK_SIZE+1)-1:0] pck_size,
    input  logic [Fpay-1:0]                   pck_hdr,
    input  logic                              dat_valid,
    output logic                              dat_ready,
    input  logic [Fpay-1:0]                   dat,
    output logic                              flit_wr,
    output logic                              flit_hdr_flag,
    output logic                              flit_tail_flag,
    output logic [V-1:0]                      flit_vc,
    output logic [Fpay-1:0]                   flit_payload,
    input  logic [V-1:0]                      credit_in,
    output logic [V*$clog2(B+1)-1:0]          vc_credit,
    output logic                              credit_err
);

    localparam int Cw = $clog2(B + 1);
    localparam int Sw = $clog2(MAX_PCK_SIZE + 1);

    inj_state_t    state;
    logic [V-1:0]  lock_vc, issue_vc, has_credit, ovf;
    logic [Sw-1:0] remaining;
    logic          legal, head_go, body_go, drop;
    flit_flag_t    nf;

    assign legal = is_onehot(32'(pck_vc)) && pck_size >= Sw'(MIN_PCK_SIZE) && pck_size <= Sw'(MAX_PCK_SIZE);
    // The head is issued straight out of IDLE, so a packet costs no setup cycle.
    assign head_go   = state == IDLE && pck_valid && legal && |(has_credit & pck_vc);
    assign drop      = state == IDLE && pck_valid && !legal;
    assign body_go   = state == BODY && dat_valid && |(has_credit & lock_vc);
    assign pck_ready = head_go || drop;
    assign dat_ready = body_go;
    assign issue_vc  = head_go ? pck_vc : body_go ? lock_vc : '0;
    assign nf.hdr    = head_go;
    assign nf.tail   = head_go ? pck_size == Sw'(1) : remaining == Sw'(1);

    for (genvar i = 0; i < V; i++) begin : g_cred
        injector_credit_counter #(.B(B), .Cw(Cw)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .issue     (issue_vc[i]),
            .ret       (credit_in[i]),
            .cnt       (vc_credit[i*Cw +: Cw]),
            .has_credit(has_credit[i]),
            .ovf       (ovf[i])
        );
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state          <= IDLE;
            lock_vc        <= '0;
            remaining      <= '0;
            flit_wr        <= 1'b0;
            flit_hdr_flag  <= 1'b0;
            flit_tail_flag <= 1'b0;
            flit_vc        <= '0;
            flit_payload   <= '0;
            credit_err     <= 1'b0;
        end else begin
            flit_wr    <= head_go || body_go;
            credit_err <= credit_err || drop || |ovf;
            if (head_go || body_go) begin
                flit_hdr_flag  <= nf.hdr;
                flit_tail_flag <= nf.tail;
                flit_vc        <= issue_vc;
                flit_payload   <= head_go ? pck_hdr : dat;
            end
            if (head_go) begin
                lock_vc   <= pck_vc;
                remaining <= pck_size - Sw'(1);
                state     <= nf.tail ? IDLE : BODY;
            end else if (body_go) begin
                remaining <= remaining - Sw'(1);
                state     <= nf.tail ? IDLE : BODY;
            end
        end

endmodule
